code_density_ctrl: RTL and testbench
====================================

# code_density_ctrl

Acquisition controller for the ADC code-density (histogram) test. It clears an internal histogram RAM and gates the SPI ADC receiver on for a programmed number of conversions. Each received code is accumulated into its bin with a saturating read-modify-write. At the end it streams every bin out over a valid/ready interface. It sits between the SPI ADC receiver (source of `d_en`/`adc_data`) and the readout path (UART/host logic).

## Interface
- `WIDTH`, 10: ADC code width; the histogram has 2^WIDTH bins.
- `CNT_W`, 24: bin counter width; bins saturate at 2^CNT_W-1.
- `clk`, in, 1: system clock (the PLL output clock of the ADC path).
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: single-cycle request to begin a run; accepted only in IDLE.
- `abort`, in, 1: cancels a run from any non-IDLE state.
- `n_samples`, in, 32: number of samples to accumulate; latched when `start` is accepted.
- `adc_en`, out, 1: enables conversions in the SPI receiver.
- `d_en`, in, 1: sample-valid pulse from the receiver.
- `adc_data`, in, WIDTH: sample code; valid when `d_en`=1.
- `busy`, out, 1: high in every state except IDLE.
- `dump_valid`, out, 1: dump beat valid.
- `dump_ready`, in, 1: downstream ready.
- `dump_bin`, out, WIDTH: bin index of the current beat.
- `dump_count`, out, CNT_W: count for that bin.
- `dump_last`, out, 1: high on the beat for bin 2^WIDTH-1.
- `done`, out, 1: one-cycle pulse after the last dump handshake.
- `overflow`, out, 1: sticky; set when any bin saturates, cleared when `start` is accepted.

## Operation
- **Histogram RAM**: internal, 2^WIDTH x CNT_W, one port with a synchronous 1-cycle read and one write port.
- **States** (FSM): IDLE, CLEAR, ACQ, DRAIN, DUMP.
- **IDLE**
  - `start`=1: latch `n_samples`, zero the sample counter, clear `overflow`, go to CLEAR.
  - `d_en` is ignored.
- **CLEAR**
  - Writes 0 to bins 0..2^WIDTH-1, one per cycle, in exactly 2^WIDTH cycles.
  - Then goes to ACQ, or to DUMP directly if the latched `n_samples`=0.
- **ACQ**
  - `adc_en`=1 while accepted samples < `n_samples`.
  - Each `d_en` in ACQ is accepted: increment the sample counter, issue a RAM read of `adc_data`.
  - When the accepted count equals `n_samples`, drop `adc_en` in the same cycle and go to DRAIN.
  - After the count is reached, further `d_en` pulses are ignored.
- **RMW pipeline**
  - Stage 0: read request.
  - Stage 1: data returns; new = old+1, saturating at 2^CNT_W-1. If old was already max, write max and set `overflow`. Write back.
  - Forwarding: if the stage-1 address equals the address written in the previous cycle, use the written value instead of the RAM output. Back-to-back `d_en` on every cycle to the same bin must count correctly.
- **DRAIN**: 2 cycles, until the pipeline is empty, then go to DUMP.
- **DUMP**
  - For k = 0..2^WIDTH-1: read bin k, then present `dump_valid`=1 with `dump_bin`=k, `dump_count`, and `dump_last`=(k==2^WIDTH-1).
  - Outputs are held stable while `dump_valid`=1 and `dump_ready`=0.
  - On handshake, drop `dump_valid` for 1 cycle while bin k+1 is read, so peak throughput is 1 beat per 2 cycles.
  - After the last handshake: pulse `done` for 1 cycle and go to IDLE.
- **abort**
  - Takes priority over all transitions except `rst`.
  - Any non-IDLE state goes to IDLE on the next edge. `adc_en`, `dump_valid` and `busy` are 0 from that edge.
  - No `done` pulse is generated.
  - RAM contents become undefined; the next `start` clears them.
  - `abort` in IDLE has no effect.
- **rst**: same effect as `abort` and additionally clears `overflow`; mid-run it behaves like abort.
- `start` while not in IDLE is ignored.

## Timing
- Reset values: `adc_en`=0, `busy`=0, `dump_valid`=0, `dump_bin`=0, `dump_count`=0, `dump_last`=0, `done`=0, `overflow`=0; the FSM is in IDLE.
- `start` accepted at edge t: `busy`=1 from t+1. CLEAR occupies t+1..t+2^WIDTH. `adc_en`=1 from t+2^WIDTH+1.
- From the last accepted `d_en` to its RAM write: 2 cycles.
- The first `dump_valid` rises 2 cycles after entering DUMP (address, then read).
- `done` is asserted the cycle after the last handshake, together with the return to IDLE.

## Test plan
- **Single hit per code**: WIDTH=4, CNT_W=8, `n_samples`=16; feed codes 0..15 once each, spaced 230 cycles. Expect 16 dump beats with count=1, `dump_last` only on bin 15, `done` once, `overflow`=0.
- **Back-to-back forwarding**: `n_samples`=4; `d_en` on 4 consecutive cycles with codes 5,5,5,7. Expect bin5=3, bin7=1, all other bins 0.
- **Saturation**: CNT_W=8, `n_samples`=300, all samples code 2. Expect bin2=255 and `overflow`=1. Next `start` clears `overflow` and bin2 reads 0 if it receives no hits.
- **Backpressure**: random `dump_ready` duty of 30%. Expect bins to arrive in order 0..15, each beat held stable while stalled, no beat lost or duplicated.
- **Abort mid-ACQ**: abort after 5 of 16 samples. Expect IDLE next cycle, `adc_en`=0, no `done`. A restart with 16 hits on code 3 gives bin3=16 and all other bins 0.
- **Zero samples / idle input**: `n_samples`=0 with `d_en` pulses applied in IDLE and in CLEAR. Expect `adc_en` never asserted and every bin to dump as 0.

Source files
------------

// File: rtl/code_density_ctrl.sv
// -----------------------------------------------------------------------------
// code_density_ctrl
//
// Acquisition controller for the ADC code-density (histogram) test.
// A run clears the internal histogram RAM, enables the SPI ADC receiver for a
// programmed number of conversions, and accumulates each received code into
// its bin with a saturating read-modify-write. It then streams every bin out
// over a valid/ready interface, from bin 0 upward.
//
// Parameters
//   WIDTH       ADC code width; the histogram has 2^WIDTH bins
//   CNT_W       bin counter width; bins saturate at 2^CNT_W-1
//
// Ports
//   clk         system clock (PLL output clock of the ADC path)
//   rst         synchronous active-high reset
//   start       single-cycle run request, honoured only in IDLE
//   abort       cancels a run from any non-IDLE state
//   n_samples   number of samples to accumulate, latched on start
//   adc_en      conversion enable towards the SPI receiver
//   d_en        sample-valid pulse from the receiver
//   adc_data    sample code, valid with d_en
//   busy        high in every state except IDLE
//   dump_valid  dump beat valid
//   dump_ready  downstream ready
//   dump_bin    bin index of the current beat
//   dump_count  count of that bin
//   dump_last   high on the beat carrying the highest bin
//   done        one-cycle pulse after the last dump handshake
//   overflow    sticky bin-saturation flag, cleared when a run starts
// -----------------------------------------------------------------------------
module code_density_ctrl #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      n_samples,
  output logic             adc_en,
  input  logic             d_en,
  input  logic [WIDTH-1:0] adc_data,
  output logic             busy,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [WIDTH-1:0] dump_bin,
  output logic [CNT_W-1:0] dump_count,
  output logic             dump_last,
  output logic             done,
  output logic             overflow
);

  localparam int               DEPTH    = 1 << WIDTH;
  localparam logic [WIDTH-1:0] LAST_BIN = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACQ   = 3'd2,
    S_DRAIN = 3'd3,
    S_DUMP  = 3'd4
  } state_t;

  // Sub-phases of a dump beat: address the bin, wait for read data, present it.
  typedef enum logic [1:0] {
    P_ADDR  = 2'd0,
    P_READ  = 2'd1,
    P_VALID = 2'd2
  } dump_ph_t;

  // Saturating increment; MSB of the result flags that the input was already
  // at full scale (the bin stays at max and overflow must be raised).
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] old_val);
    logic [CNT_W:0] res;
    if (old_val == CNT_MAX) begin
      res = {1'b1, CNT_MAX};
    end else begin
      res = {1'b0, old_val + CNT_W'(1)};
    end
    return res;
  endfunction

  // FSM and output registers
  state_t           state_r;
  dump_ph_t         ph_r;
  logic [31:0]      n_lat_r;
  logic [31:0]      acc_cnt_r;
  logic [WIDTH-1:0] clr_addr_r;
  logic             drain_cnt_r;
  logic [WIDTH-1:0] dump_k_r;
  logic             adc_en_r;
  logic             busy_r;
  logic             dump_valid_r;
  logic [WIDTH-1:0] dump_bin_r;
  logic [CNT_W-1:0] dump_count_r;
  logic             dump_last_r;
  logic             done_r;
  logic             overflow_r;

  // RMW pipeline registers
  logic             s1_vld_r;
  logic [WIDTH-1:0] s1_addr_r;
  logic             wr_vld_r;
  logic [WIDTH-1:0] wr_addr_r;
  logic [CNT_W-1:0] wr_data_r;

  // Histogram RAM
  logic [CNT_W-1:0] mem_r [DEPTH];
  logic [CNT_W-1:0] rd_data_r;

  // Combinational control
  logic             acc_s;
  logic             acc_last_s;
  logic             rd_en_s;
  logic [WIDTH-1:0] rd_addr_s;
  logic             wr_en_s;
  logic [WIDTH-1:0] wr_addr_s;
  logic [CNT_W-1:0] wr_data_s;
  logic             fwd_s;
  logic [CNT_W-1:0] old_s;
  logic [CNT_W-1:0] new_s;
  logic             sat_s;

  // An abort on the same edge wins over a sample, so the sample is dropped.
  assign acc_s      = (state_r == S_ACQ) && adc_en_r && d_en && !abort;
  assign acc_last_s = acc_s && ((acc_cnt_r + 32'd1) == n_lat_r);

  // Stage 1: the RAM read issued last edge cannot see the write committed on
  // that same edge, so take the just-written value when the bin matches.
  assign fwd_s          = wr_vld_r && (wr_addr_r == s1_addr_r);
  assign old_s          = fwd_s ? wr_data_r : rd_data_r;
  assign {sat_s, new_s} = sat_inc(old_s);

  // Read port select: sample bins during acquisition, dump bins during dump
  always_comb begin
    rd_en_s   = 1'b0;
    rd_addr_s = {WIDTH{1'b0}};
    if (acc_s) begin
      rd_en_s   = 1'b1;
      rd_addr_s = adc_data;
    end else if ((state_r == S_DUMP) && (ph_r == P_ADDR)) begin
      rd_en_s   = 1'b1;
      rd_addr_s = dump_k_r;
    end else if ((state_r == S_DUMP) && (ph_r == P_VALID) && dump_valid_r && dump_ready) begin
      // Prefetch the next bin on the handshake edge for 2-cycle beats.
      rd_en_s   = 1'b1;
      rd_addr_s = dump_k_r + WIDTH'(1);
    end else begin
      rd_en_s   = 1'b0;
      rd_addr_s = {WIDTH{1'b0}};
    end
  end

  // Write port select: RMW write-back, otherwise clearing sweep
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = {WIDTH{1'b0}};
    wr_data_s = {CNT_W{1'b0}};
    if (s1_vld_r) begin
      wr_en_s   = 1'b1;
      wr_addr_s = s1_addr_r;
      wr_data_s = new_s;
    end else if (state_r == S_CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_addr_r;
      wr_data_s = {CNT_W{1'b0}};
    end else begin
      wr_en_s   = 1'b0;
      wr_addr_s = {WIDTH{1'b0}};
      wr_data_s = {CNT_W{1'b0}};
    end
  end

  // Histogram RAM: one synchronous read port and one write port
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
    if (rd_en_s) begin
      rd_data_r <= mem_r[rd_addr_s];
    end
  end

  // RMW pipeline: stage-1 tracking and record of the last committed write
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_r  <= 1'b0;
      s1_addr_r <= {WIDTH{1'b0}};
      wr_vld_r  <= 1'b0;
      wr_addr_r <= {WIDTH{1'b0}};
      wr_data_r <= {CNT_W{1'b0}};
    end else begin
      s1_vld_r  <= acc_s;
      s1_addr_r <= adc_data;
      wr_vld_r  <= wr_en_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
    end
  end

  // Run-control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      ph_r         <= P_ADDR;
      n_lat_r      <= 32'd0;
      acc_cnt_r    <= 32'd0;
      clr_addr_r   <= {WIDTH{1'b0}};
      drain_cnt_r  <= 1'b0;
      dump_k_r     <= {WIDTH{1'b0}};
      adc_en_r     <= 1'b0;
      busy_r       <= 1'b0;
      dump_valid_r <= 1'b0;
      dump_bin_r   <= {WIDTH{1'b0}};
      dump_count_r <= {CNT_W{1'b0}};
      dump_last_r  <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (s1_vld_r && sat_s) begin
        overflow_r <= 1'b1;
      end
      if (abort && (state_r != S_IDLE)) begin
        state_r      <= S_IDLE;
        adc_en_r     <= 1'b0;
        busy_r       <= 1'b0;
        dump_valid_r <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start) begin
              n_lat_r    <= n_samples;
              acc_cnt_r  <= 32'd0;
              overflow_r <= 1'b0;
              clr_addr_r <= {WIDTH{1'b0}};
              busy_r     <= 1'b1;
              state_r    <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            clr_addr_r <= clr_addr_r + WIDTH'(1);
            if (clr_addr_r == LAST_BIN) begin
              if (n_lat_r == 32'd0) begin
                state_r  <= S_DUMP;
                ph_r     <= P_ADDR;
                dump_k_r <= {WIDTH{1'b0}};
              end else begin
                state_r  <= S_ACQ;
                adc_en_r <= 1'b1;
              end
            end
          end
          S_ACQ: begin
            if (acc_s) begin
              acc_cnt_r <= acc_cnt_r + 32'd1;
              if (acc_last_s) begin
                adc_en_r    <= 1'b0;
                drain_cnt_r <= 1'b0;
                state_r     <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            // Two cycles let the final write-back land before bin 0 is read.
            if (drain_cnt_r) begin
              state_r  <= S_DUMP;
              ph_r     <= P_ADDR;
              dump_k_r <= {WIDTH{1'b0}};
            end else begin
              drain_cnt_r <= 1'b1;
            end
          end
          S_DUMP: begin
            case (ph_r)
              P_ADDR: begin
                ph_r <= P_READ;
              end
              P_READ: begin
                dump_valid_r <= 1'b1;
                dump_bin_r   <= dump_k_r;
                dump_count_r <= rd_data_r;
                dump_last_r  <= (dump_k_r == LAST_BIN);
                ph_r         <= P_VALID;
              end
              P_VALID: begin
                if (dump_ready) begin
                  dump_valid_r <= 1'b0;
                  if (dump_last_r) begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                  end else begin
                    dump_k_r <= dump_k_r + WIDTH'(1);
                    ph_r     <= P_READ;
                  end
                end
              end
              default: begin
                ph_r <= P_ADDR;
              end
            endcase
          end
          default: begin
            state_r      <= S_IDLE;
            adc_en_r     <= 1'b0;
            busy_r       <= 1'b0;
            dump_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign adc_en     = adc_en_r;
  assign busy       = busy_r;
  assign dump_valid = dump_valid_r;
  assign dump_bin   = dump_bin_r;
  assign dump_count = dump_count_r;
  assign dump_last  = dump_last_r;
  assign done       = done_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_code_density_ctrl.sv
// -----------------------------------------------------------------------------
// tb_code_density_ctrl
//
// Directed self-checking bench for code_density_ctrl with a 16-bin, 8-bit
// histogram. Expected bin counts come from a saturating reference histogram
// filled alongside the stimulus; timing points are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_code_density_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [31:0]   n_samples;
  logic          adc_en;
  logic          d_en;
  logic [W-1:0]  adc_data;
  logic          busy;
  logic          dump_valid;
  logic          dump_ready;
  logic [W-1:0]  dump_bin;
  logic [CW-1:0] dump_count;
  logic          dump_last;
  logic          done;
  logic          overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int done_pulses   = 0;
  int adc_en_cycles = 0;
  int exp_h [NB];

  code_density_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .n_samples  (n_samples),
    .adc_en     (adc_en),
    .d_en       (d_en),
    .adc_data   (adc_data),
    .busy       (busy),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_bin   (dump_bin),
    .dump_count (dump_count),
    .dump_last  (dump_last),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    if (done)   done_pulses++;
    if (adc_en) adc_en_cycles++;
  end

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) exp_h[i] = 0;
  endtask

  task automatic add_hit(input int code);
    if (exp_h[code] < 255) exp_h[code] = exp_h[code] + 1;
  endtask

  task automatic start_run(input logic [31:0] n);
    n_samples = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check_val("busy_after_start", 32'(busy), 32'd1);
  endtask

  // CLEAR takes 16 cycles; adc_en rises after the 16th clear edge.
  task automatic wait_acq();
    repeat (15) tick();
    check_val("adc_en_during_clear", 32'(adc_en), 32'd0);
    tick();
    check_val("adc_en_rise", 32'(adc_en), 32'd1);
  endtask

  task automatic feed(input logic [W-1:0] code);
    adc_data = code;
    d_en     = 1'b1;
    tick();
    d_en     = 1'b0;
  endtask

  task automatic dump_and_check(input bit bp);
    int beat;
    int cyc;
    bit held;
    int d0;
    logic [W-1:0]  sb;
    logic [CW-1:0] sc;
    logic          sl;
    beat = 0; cyc = 0; held = 1'b0; d0 = done_pulses;
    sb = '0; sc = '0; sl = 1'b0;
    while ((beat < NB) && (cyc < 3000)) begin
      if (held) begin
        check_val("valid_held", 32'(dump_valid), 32'd1);
        check_val("bin_stable", 32'(dump_bin), 32'(sb));
        check_val("count_stable", 32'(dump_count), 32'(sc));
        check_val("last_stable", 32'(dump_last), 32'(sl));
      end else if (dump_valid) begin
        check_val("dump_bin", 32'(dump_bin), 32'(beat));
        check_val("dump_count", 32'(dump_count), 32'(exp_h[beat]));
        check_val("dump_last", 32'(dump_last), 32'(beat == NB - 1));
        sb = dump_bin; sc = dump_count; sl = dump_last;
      end
      dump_ready = bp ? ($urandom_range(0, 99) < 32'd30) : 1'b1;
      if (dump_valid) begin
        held = !dump_ready;
        if (dump_ready) beat++;
      end else begin
        held = 1'b0;
      end
      tick();
      cyc++;
    end
    dump_ready = 1'b0;
    check_val("dump_beats", 32'(beat), 32'(NB));
    check_val("done_after_last", 32'(done), 32'd1);
    check_val("busy_after_done", 32'(busy), 32'd0);
    check_val("valid_after_done", 32'(dump_valid), 32'd0);
    tick();
    check_val("done_one_cycle", 32'(done), 32'd0);
    check_val("done_count", 32'(done_pulses - d0), 32'd1);
  endtask

  initial begin
    int d0;
    int a0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; n_samples = 32'd0;
    d_en = 1'b0; adc_data = '0; dump_ready = 1'b0;
    tick();
    tick();
    check_val("rst_adc_en", 32'(adc_en), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_dump_valid", 32'(dump_valid), 32'd0);
    check_val("rst_dump_bin", 32'(dump_bin), 32'd0);
    check_val("rst_dump_count", 32'(dump_count), 32'd0);
    check_val("rst_dump_last", 32'(dump_last), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // Single hit per code, spaced 230 cycles
    clear_model();
    start_run(32'd16);
    wait_acq();
    for (int i = 0; i < NB; i++) begin
      feed(W'(i));
      add_hit(i);
      if (i < NB - 1) repeat (229) tick();
    end
    check_val("t1_adc_en_drop", 32'(adc_en), 32'd0);
    dump_and_check(1'b0);
    check_val("t1_overflow", 32'(overflow), 32'd0);

    // Back-to-back same-bin hits, then first-beat latency
    clear_model();
    start_run(32'd4);
    wait_acq();
    d_en = 1'b1;
    adc_data = 4'd5; tick(); add_hit(5);
    adc_data = 4'd5; tick(); add_hit(5);
    adc_data = 4'd5; tick(); add_hit(5);
    adc_data = 4'd7; tick(); add_hit(7);
    d_en = 1'b0;
    check_val("t2_adc_en_drop", 32'(adc_en), 32'd0);
    repeat (3) tick();
    check_val("t2_valid_not_yet", 32'(dump_valid), 32'd0);
    tick();
    check_val("t2_first_valid", 32'(dump_valid), 32'd1);
    dump_and_check(1'b0);

    // Saturation with continuous d_en running past the sample count
    clear_model();
    start_run(32'd300);
    wait_acq();
    d_en = 1'b1;
    adc_data = 4'd2;
    for (int i = 0; i < 305; i++) begin
      tick();
      if (i < 300) add_hit(2);
    end
    d_en = 1'b0;
    check_val("t3_adc_en_drop", 32'(adc_en), 32'd0);
    check_val("t3_overflow_set", 32'(overflow), 32'd1);
    dump_and_check(1'b0);
    check_val("t3_overflow_sticky", 32'(overflow), 32'd1);
    clear_model();
    start_run(32'd1);
    check_val("t3_overflow_cleared", 32'(overflow), 32'd0);
    wait_acq();
    feed(4'd9);
    add_hit(9);
    dump_and_check(1'b0);

    // Random backpressure on the dump
    clear_model();
    start_run(32'd16);
    wait_acq();
    for (int i = 0; i < NB; i++) begin
      feed(W'((i * 3) & 7));
      add_hit((i * 3) & 7);
      tick();
    end
    dump_and_check(1'b1);

    // Abort mid-acquisition, abort in IDLE, then restart
    clear_model();
    start_run(32'd16);
    wait_acq();
    for (int i = 0; i < 5; i++) begin
      feed(4'd1);
      tick();
    end
    d0 = done_pulses;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("t5_busy_abort", 32'(busy), 32'd0);
    check_val("t5_adc_en_abort", 32'(adc_en), 32'd0);
    check_val("t5_valid_abort", 32'(dump_valid), 32'd0);
    repeat (20) tick();
    check_val("t5_no_done", 32'(done_pulses - d0), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("t5_abort_idle", 32'(busy), 32'd0);
    clear_model();
    start_run(32'd16);
    wait_acq();
    d_en = 1'b1;
    adc_data = 4'd3;
    for (int i = 0; i < 16; i++) begin
      tick();
      add_hit(3);
    end
    d_en = 1'b0;
    dump_and_check(1'b0);

    // Zero samples with d_en in IDLE and CLEAR, plus a start ignored while busy
    clear_model();
    a0 = adc_en_cycles;
    d_en = 1'b1;
    adc_data = 4'd6;
    repeat (3) tick();
    d_en = 1'b0;
    check_val("t6_idle_busy", 32'(busy), 32'd0);
    start_run(32'd0);
    d_en = 1'b1;
    start = 1'b1;
    n_samples = 32'd5;
    repeat (5) tick();
    d_en = 1'b0;
    start = 1'b0;
    dump_and_check(1'b0);
    check_val("t6_adc_en_never", 32'(adc_en_cycles - a0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
